// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO read-mode constants and pointer sizing helper.
package fifo_pkg;
    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Index bits plus one wrap bit so full and empty stay distinguishable.
    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/param_fifo_if.sv
// param_fifo_if: push/pop handshake, status flags and occupancy of one FIFO.
interface param_fifo_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8
);
    logic                       write_enable;
    logic [DATA_WIDTH-1:0]      write_data;
    logic                       write_full;
    logic                       write_almost_full;
    logic                       read_enable;
    logic [DATA_WIDTH-1:0]      read_data;
    logic                       read_valid;
    logic                       read_empty;
    logic                       read_almost_empty;
    logic [$clog2(DEPTH):0]     level;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output write_enable, write_data, read_enable,
        input  write_full, write_almost_full, read_data, read_valid,
        input  read_empty, read_almost_empty, level, overflow, underflow
    );
    modport slave (
        input  write_enable, write_data, read_enable,
        output write_full, write_almost_full, read_data, read_valid,
        output read_empty, read_almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write, asynchronous read, no reset.
module fifo_mem #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [AW-1:0]         write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [AW-1:0]         read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (write_en) mem[write_addr] <= write_data;

    assign read_data = mem[read_addr];
endmodule

// File: rtl/param_fifo.sv
// param_fifo: synchronous FIFO with registered or first-word-fall-through read,
// programmable almost flags and sticky overflow/underflow.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = FIFO_MODE_REG,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         clear_flags,
    param_fifo_if.slave  bus
);
    localparam int PW = fifo_ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0]         wr_ptr, rd_ptr, lvl;
    logic [DATA_WIDTH-1:0] head, rd_q;
    logic                  rv_q, ovf_q, unf_q, wr_ok, rd_ok;

    // Status is a pure function of the registered pointers.
    assign lvl                   = wr_ptr - rd_ptr;
    assign bus.level             = lvl;
    assign bus.write_full        = lvl == PW'(DEPTH);
    assign bus.read_empty        = lvl == '0;
    assign bus.write_almost_full = lvl >= PW'(AF_THRESH);
    assign bus.read_almost_empty = lvl <= PW'(AE_THRESH);
    assign bus.overflow          = ovf_q;
    assign bus.underflow         = unf_q;

    assign wr_ok = bus.write_enable && !bus.write_full;
    assign rd_ok = bus.read_enable && !bus.read_empty;

    fifo_mem #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_mem (
        .clk        (clk),
        .write_en   (wr_ok && !flush),
        .write_addr (wr_ptr[AW-1:0]),
        .write_data (bus.write_data),
        .read_addr  (rd_ptr[AW-1:0]),
        .read_data  (head)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rv_q   <= 1'b0;
            rd_q   <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            ovf_q <= (bus.write_enable && bus.write_full) || (ovf_q && !clear_flags);
            unf_q <= (bus.read_enable && bus.read_empty) || (unf_q && !clear_flags);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                rv_q   <= 1'b0;
            end else begin
                if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
                if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
                if (rd_ok) rd_q <= head;
                rv_q <= rd_ok;
            end
        end
    end

    // FWFT exposes the memory head directly; registered mode shows the last pop.
    assign bus.read_data  = (FWFT == FIFO_MODE_FWFT) ? head : rd_q;
    assign bus.read_valid = (FWFT == FIFO_MODE_FWFT) ? !bus.read_empty : rv_q;
endmodule
